// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: reorder-buffer tag allocator and in-order commit sequencer.
// Drives the regfile ROB write port and the machine-wide clear on mispredict.
module rob_commit_ctrl #(
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 15,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              id_alloc_valid,
  input  logic [4:0]        id_alloc_rd,
  output logic [TAG_W-1:0]  id_alloc_tag,
  output logic              rob_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_mispredict,
  input  logic [DATA_W-1:0] cdb_target_pc,
  output logic              commit_valid,
  output logic [4:0]        commit_rd,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [DATA_W-1:0] commit_data,
  output logic              clear,
  output logic [DATA_W-1:0] clear_pc
);

  localparam int NENT = 2 ** TAG_W;
  localparam logic [TAG_W-1:0] LAST = TAG_W'(DEPTH);
  localparam logic [TAG_W-1:0] ONE  = TAG_W'(1);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W-1:0] count_q, count_d;

  // Entry control bits, indexed directly by tag; bit 0 never gets set.
  logic [NENT-1:0] busy_q, busy_d;
  logic [NENT-1:0] ready_q, ready_d;
  logic [NENT-1:0] mp_q, mp_d;

  logic [4:0]        rd_q   [NENT];
  logic [DATA_W-1:0] data_q [NENT];
  logic [DATA_W-1:0] tgt_q  [NENT];

  logic              cv_q;
  logic [4:0]        crd_q;
  logic [TAG_W-1:0]  ctag_q;
  logic [DATA_W-1:0] cdata_q;
  logic              clr_q;
  logic [DATA_W-1:0] clrpc_q;
  logic [DATA_W-1:0] fpc_q;

  logic alloc_fire;
  logic cdb_hit;
  logic commit_fire;
  logic flush_now;

  function automatic logic [TAG_W-1:0] nxt(
    input logic [TAG_W-1:0] t
  );
    return (t == LAST) ? ONE : t + ONE;
  endfunction

  assign rob_full = (count_q == LAST)
                  | (state_q == FLUSH)
                  | !rst;

  assign id_alloc_tag = tail_q;

  assign alloc_fire  = id_alloc_valid & !rob_full;
  assign cdb_hit     = cdb_valid & busy_q[cdb_tag];
  assign commit_fire = (state_q == RUN)
                     & busy_q[head_q]
                     & ready_q[head_q];
  assign flush_now   = commit_fire & mp_q[head_q];

  assign commit_valid = cv_q;
  assign commit_rd    = crd_q;
  assign commit_tag   = ctag_q;
  assign commit_data  = cdata_q;
  assign clear        = clr_q;
  assign clear_pc     = clrpc_q;

  // Next-state for pointers, occupancy and per-entry flags.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    mp_d    = mp_q;
    if (flush_now) begin
      state_d = FLUSH;
      head_d  = ONE;
      tail_d  = ONE;
      count_d = '0;
      busy_d  = '0;
      ready_d = '0;
      mp_d    = '0;
    end else begin
      if (state_q == FLUSH) state_d = RUN;
      if (alloc_fire) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        mp_d[tail_q]    = 1'b0;
        tail_d          = nxt(tail_q);
      end
      if (cdb_hit) begin
        ready_d[cdb_tag] = 1'b1;
        mp_d[cdb_tag]    = cdb_mispredict;
      end
      if (commit_fire) begin
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = nxt(head_q);
      end
      count_d = count_q
              + TAG_W'(alloc_fire)
              - TAG_W'(commit_fire);
    end
  end

  // Control state, commit port and clear pulse; rdy=0 freezes all of it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      head_q  <= ONE;
      tail_q  <= ONE;
      count_q <= '0;
      busy_q  <= '0;
      ready_q <= '0;
      mp_q    <= '0;
      cv_q    <= 1'b0;
      crd_q   <= '0;
      ctag_q  <= '0;
      cdata_q <= '0;
      clr_q   <= 1'b0;
      clrpc_q <= '0;
      fpc_q   <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      mp_q    <= mp_d;
      cv_q    <= commit_fire;
      if (commit_fire) begin
        crd_q   <= rd_q[head_q];
        ctag_q  <= head_q;
        cdata_q <= data_q[head_q];
        fpc_q   <= tgt_q[head_q];
      end
      clr_q <= (state_q == FLUSH);
      if (state_q == FLUSH) clrpc_q <= fpc_q;
    end
  end

  // Entry payload; only read while busy and ready, so it needs no reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (alloc_fire) rd_q[tail_q] <= id_alloc_rd;
      if (cdb_hit) begin
        data_q[cdb_tag] <= cdb_data;
        tgt_q[cdb_tag]  <= cdb_target_pc;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb_rob_commit_ctrl: directed vectors for the ROB commit sequencer.
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_rob_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        id_alloc_valid;
  logic [4:0]  id_alloc_rd;
  logic [3:0]  id_alloc_tag;
  logic        rob_full;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_mispredict;
  logic [31:0] cdb_target_pc;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_tag;
  logic [31:0] commit_data;
  logic        clear;
  logic [31:0] clear_pc;

  int errs   = 0;
  int checks = 0;
  int writes = 0;

  rob_commit_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .id_alloc_valid(id_alloc_valid),
    .id_alloc_rd   (id_alloc_rd),
    .id_alloc_tag  (id_alloc_tag),
    .rob_full      (rob_full),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .cdb_mispredict(cdb_mispredict),
    .cdb_target_pc (cdb_target_pc),
    .commit_valid  (commit_valid),
    .commit_rd     (commit_rd),
    .commit_tag    (commit_tag),
    .commit_data   (commit_data),
    .clear         (clear),
    .clear_pc      (clear_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst && rdy && commit_valid) writes <= writes + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cdb(
    input logic [3:0]  t,
    input logic [31:0] d,
    input logic        mp,
    input logic [31:0] pc
  );
    cdb_valid      = 1'b1;
    cdb_tag        = t;
    cdb_data       = d;
    cdb_mispredict = mp;
    cdb_target_pc  = pc;
  endtask

  logic [3:0] t;
  logic [3:0] tp;

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    id_alloc_valid = 1'b0;
    id_alloc_rd = 5'd0;
    cdb_valid = 1'b0;
    cdb_tag = 4'd0;
    cdb_data = 32'd0;
    cdb_mispredict = 1'b0;
    cdb_target_pc = 32'd0;
    step();
    step();
    chk("rst_cv",   32'(commit_valid), 32'd0);
    chk("rst_clr",  32'(clear), 32'd0);
    chk("rst_rd",   32'(commit_rd), 32'd0);
    chk("rst_tag",  32'(commit_tag), 32'd0);
    chk("rst_data", commit_data, 32'd0);
    chk("rst_pc",   clear_pc, 32'd0);
    chk("rst_full", 32'(rob_full), 32'd1);
    chk("rst_atag", 32'(id_alloc_tag), 32'd1);
    rst = 1'b1;
    #1;
    chk("run_full", 32'(rob_full), 32'd0);

    // Three allocations, out-of-order completion, in-order commit.
    id_alloc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_alloc_rd = 5'(5 + i);
      chk("a3_tag", 32'(id_alloc_tag), 32'(i + 1));
      step();
    end
    id_alloc_valid = 1'b0;
    cdb(4'd3, 32'h33, 1'b0, 32'd0);
    step();
    chk("early_cv", 32'(commit_valid), 32'd0);
    cdb(4'd1, 32'h11, 1'b0, 32'd0);
    step();
    chk("hold_cv", 32'(commit_valid), 32'd0);
    cdb(4'd2, 32'h22, 1'b0, 32'd0);
    step();
    cdb_valid = 1'b0;
    chk("c1_cv",   32'(commit_valid), 32'd1);
    chk("c1_tag",  32'(commit_tag), 32'd1);
    chk("c1_rd",   32'(commit_rd), 32'd5);
    chk("c1_data", commit_data, 32'h11);
    step();
    chk("c2_tag",  32'(commit_tag), 32'd2);
    chk("c2_rd",   32'(commit_rd), 32'd6);
    chk("c2_data", commit_data, 32'h22);
    step();
    chk("c3_tag",  32'(commit_tag), 32'd3);
    chk("c3_rd",   32'(commit_rd), 32'd7);
    chk("c3_data", commit_data, 32'h33);
    step();
    chk("c4_cv",   32'(commit_valid), 32'd0);

    // Fill all 15 entries starting at tag 4: tags 4..15 then 1..3.
    id_alloc_valid = 1'b1;
    id_alloc_rd = 5'd10;
    for (int i = 0; i < 15; i++) begin
      chk("fill_full", 32'(rob_full), 32'd0);
      chk("fill_tag", 32'(id_alloc_tag), 32'(((3 + i) % 15) + 1));
      step();
    end
    chk("full", 32'(rob_full), 32'd1);
    chk("full_tag", 32'(id_alloc_tag), 32'd4);
    step();
    chk("ovf_full", 32'(rob_full), 32'd1);
    chk("ovf_tag", 32'(id_alloc_tag), 32'd4);

    // Head ready while full: commit wins, alloc waits one cycle.
    id_alloc_valid = 1'b0;
    cdb(4'd4, 32'h104, 1'b0, 32'd0);
    step();
    cdb_valid = 1'b0;
    id_alloc_valid = 1'b1;
    id_alloc_rd = 5'd9;
    chk("fc_full", 32'(rob_full), 32'd1);
    step();
    chk("fc_cv",   32'(commit_valid), 32'd1);
    chk("fc_tag",  32'(commit_tag), 32'd4);
    chk("fc_full2", 32'(rob_full), 32'd0);
    chk("fc_atag", 32'(id_alloc_tag), 32'd4);
    step();
    id_alloc_valid = 1'b0;
    chk("fa_atag", 32'(id_alloc_tag), 32'd5);
    chk("fa_full", 32'(rob_full), 32'd1);
    chk("fa_cv",   32'(commit_valid), 32'd0);

    // Drain in order 5..15,1..4; commit trails completion by a cycle.
    for (int k = 0; k < 15; k++) begin
      t = 4'(((4 + k) % 15) + 1);
      cdb(t, 32'h100 + 32'(t), 1'b0, 32'd0);
      step();
      if (k > 0) begin
        chk("dr_cv",   32'(commit_valid), 32'd1);
        chk("dr_tag",  32'(commit_tag), 32'(tp));
        chk("dr_data", commit_data, 32'h100 + 32'(tp));
      end
      tp = t;
    end
    cdb_valid = 1'b0;
    step();
    chk("dr_last", 32'(commit_tag), 32'd4);
    chk("dr_rd",   32'(commit_rd), 32'd9);
    step();
    chk("dr_idle", 32'(commit_valid), 32'd0);
    chk("dr_atag", 32'(id_alloc_tag), 32'd5);

    // Mispredicted branch at tag 5 followed by a ready tag 6.
    id_alloc_valid = 1'b1;
    id_alloc_rd = 5'd1;
    step();
    id_alloc_rd = 5'd2;
    step();
    id_alloc_valid = 1'b0;
    cdb(4'd6, 32'h66, 1'b0, 32'd0);
    step();
    cdb(4'd5, 32'h8, 1'b1, 32'h100);
    step();
    cdb_valid = 1'b0;
    step();
    chk("br_cv",   32'(commit_valid), 32'd1);
    chk("br_tag",  32'(commit_tag), 32'd5);
    chk("br_rd",   32'(commit_rd), 32'd1);
    chk("br_data", commit_data, 32'h8);
    chk("br_clr0", 32'(clear), 32'd0);
    chk("fl_full", 32'(rob_full), 32'd1);
    id_alloc_valid = 1'b1;
    id_alloc_rd = 5'd3;
    step();
    chk("fl_clr",  32'(clear), 32'd1);
    chk("fl_pc",   clear_pc, 32'h100);
    chk("fl_cv",   32'(commit_valid), 32'd0);
    chk("fl_atag", 32'(id_alloc_tag), 32'd1);
    chk("fl_full2", 32'(rob_full), 32'd0);
    step();
    id_alloc_valid = 1'b0;
    chk("pf_clr",  32'(clear), 32'd0);
    chk("pf_cv",   32'(commit_valid), 32'd0);
    chk("pf_atag", 32'(id_alloc_tag), 32'd2);

    // Commit tag 1, then freeze with rdy=0 for three cycles.
    cdb(4'd1, 32'hAB, 1'b0, 32'd0);
    step();
    cdb_valid = 1'b0;
    writes = 0;
    step();
    chk("fz_cv",   32'(commit_valid), 32'd1);
    chk("fz_tag",  32'(commit_tag), 32'd1);
    chk("fz_rd",   32'(commit_rd), 32'd3);
    rdy = 1'b0;
    id_alloc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fz_hcv",  32'(commit_valid), 32'd1);
      chk("fz_hdat", commit_data, 32'hAB);
      chk("fz_atag", 32'(id_alloc_tag), 32'd2);
    end
    id_alloc_valid = 1'b0;
    rdy = 1'b1;
    step();
    chk("fz_writes", 32'(writes), 32'd1);
    chk("fz_done", 32'(commit_valid), 32'd0);

    // Reset clears held outputs.
    rst = 1'b0;
    step();
    chk("r2_cv",   32'(commit_valid), 32'd0);
    chk("r2_data", commit_data, 32'd0);
    chk("r2_rd",   32'(commit_rd), 32'd0);
    chk("r2_tag",  32'(commit_tag), 32'd0);
    chk("r2_pc",   clear_pc, 32'd0);
    chk("r2_full", 32'(rob_full), 32'd1);
    chk("r2_atag", 32'(id_alloc_tag), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
